// File: rtl/flag_int_ctrl.sv
// RAT CPU flag controller: live C/Z/I flags, INTR synchronizer with pending latch,
// and an IDLE/ENTER/ISR sequencer that shadows C/Z on entry and restores them on RETIE.
module flag_int_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter bit ISR_GUARD   = 1'b1
) (
  input  logic clk,
  input  logic RST_N,
  input  logic C_IN,
  input  logic Z_IN,
  input  logic C_LD,
  input  logic C_SET,
  input  logic C_CLEAR,
  input  logic Z_LD,
  input  logic I_SET,
  input  logic I_CLEAR,
  input  logic INTR,
  input  logic INSTR_BND,
  input  logic RETIE,
  input  logic RETIE_EN,
  output logic C_FLAG,
  output logic Z_FLAG,
  output logic I_FLAG,
  output logic INT_TAKEN,
  output logic IN_ISR
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ENTER = 2'd1;
  localparam logic [1:0] ISR   = 2'd2;

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_d;
  logic                   pending;
  logic                   sh_c, sh_z;
  logic                   c_q, z_q, i_q;
  logic                   take, restore, sync_rise, pend_ok;

  assign take      = (state == IDLE) && pending && i_q && INSTR_BND;
  assign restore   = (state == ISR) && RETIE;
  assign sync_rise = sync[SYNC_STAGES-1] & ~sync_d;
  // Outside IDLE a new request is only remembered when the guard is enabled.
  assign pend_ok   = (state == IDLE) || ISR_GUARD;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sync    <= '0;
      sync_d  <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], INTR};
      sync_d  <= sync[SYNC_STAGES-1];
      pending <= (pending & ~take) | (sync_rise & pend_ok);
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (take) state <= ENTER;
        ENTER:   state <= ISR;
        ISR:     if (RETIE) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sh_c <= 1'b0;
      sh_z <= 1'b0;
    end else if (state == ENTER) begin
      sh_c <= c_q;
      sh_z <= z_q;
    end
  end

  // Restore on RETIE wins over any same-cycle flag op.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
      i_q <= 1'b0;
    end else begin
      if (restore)      c_q <= sh_c;
      else if (C_CLEAR) c_q <= 1'b0;
      else if (C_SET)   c_q <= 1'b1;
      else if (C_LD)    c_q <= C_IN;

      if (restore)      z_q <= sh_z;
      else if (Z_LD)    z_q <= Z_IN;

      if (restore)                      i_q <= RETIE_EN;
      else if (state == ENTER)          i_q <= 1'b0;
      else if (I_CLEAR)                 i_q <= 1'b0;
      else if (I_SET && state == IDLE)  i_q <= 1'b1;
    end
  end

  assign C_FLAG    = c_q;
  assign Z_FLAG    = z_q;
  assign I_FLAG    = i_q;
  assign INT_TAKEN = (state == ENTER);
  assign IN_ISR    = (state == ISR);

endmodule

// File: doc/flag_int_ctrl.md
Name: flag_int_ctrl

Overview:
- Controller for the RAT CPU status flags (C, Z) and the interrupt-enable flag (I).
- Sequences interrupt entry and exit around those flags:
  - synchronizes the external interrupt line;
  - accepts an interrupt only at an instruction boundary;
  - saves C/Z into shadow registers on entry;
  - restores C/Z and re-enables interrupts on RETIE.
- Sits between the control unit FSM, the ALU flag outputs and the program counter vector mux.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages synchronizing INTR; legal range 2..4.
- ISR_GUARD, 1, if 1, INTR pulses that arrive while IN_ISR=1 are latched and serviced after RETIE; if 0, they are dropped.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- C_IN  input  1  carry result from the ALU.
- Z_IN  input  1  zero result from the ALU.
- C_LD  input  1  load C_IN into C.
- C_SET  input  1  set C.
- C_CLEAR  input  1  clear C.
- Z_LD  input  1  load Z_IN into Z.
- I_SET  input  1  SEI instruction strobe.
- I_CLEAR  input  1  CLI instruction strobe.
- INTR  input  1  asynchronous external interrupt request, active high.
- INSTR_BND  input  1  control unit is at a fetch boundary; an interrupt may be taken this cycle.
- RETIE  input  1  return-from-interrupt strobe.
- RETIE_EN  input  1  value written to I on RETIE (RETIE=1, RETID=0).
- C_FLAG  output  1  live carry flag.
- Z_FLAG  output  1  live zero flag.
- I_FLAG  output  1  interrupt-enable flag.
- INT_TAKEN  output  1  one-cycle pulse; control unit loads the ISR vector into the PC.
- IN_ISR  output  1  high from interrupt entry until RETIE.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - C_FLAG, Z_FLAG, I_FLAG, shadow C, shadow Z, pending latch, synchronizer chain, INT_TAKEN and IN_ISR all go to 0.
  - The FSM goes to IDLE.
  - Reset in any state aborts the operation in progress; no restore occurs.
- Live flag updates, registered, applied when no restore is active:
  - C priority: C_CLEAR > C_SET > C_LD > hold.
  - Z: Z_LD loads Z_IN, otherwise hold.
  - I priority: I_CLEAR > I_SET > hold.
- Synchronizer and pending latch:
  - INTR passes through SYNC_STAGES flops.
  - A rising edge on the synchronized signal sets `pending`; INTR held high produces one request only.
  - `pending` clears in the cycle INT_TAKEN is asserted.
  - Latency from INTR rising to `pending`=1 is SYNC_STAGES+1 edges.
- FSM states: IDLE, ENTER, ISR.
  - IDLE -> ENTER when pending=1 and I_FLAG=1 and INSTR_BND=1. Otherwise remain in IDLE; pending stays latched while I_FLAG=0.
  - ENTER, one cycle:
    - INT_TAKEN=1.
    - shadow C/Z <= the C_FLAG/Z_FLAG values present before this edge.
    - I_FLAG <= 0, overriding I_SET in the same cycle.
    - IN_ISR <= 1.
    - Live C/Z ops requested in this cycle still apply to the live flags.
    - Transition to ISR.
  - ISR:
    - INTR edges set `pending` only if ISR_GUARD=1.
    - No new entry, because I_FLAG=0 and the FSM is not in IDLE.
    - I_SET inside ISR is ignored; nesting is unsupported.
  - ISR -> IDLE on RETIE=1:
    - C_FLAG <= shadow C and Z_FLAG <= shadow Z, overriding any same-cycle C_/Z_ ops.
    - I_FLAG <= RETIE_EN.
    - IN_ISR <= 0.
  - RETIE in IDLE or ENTER is ignored.
- Back-to-back interrupts:
  - If pending=1 at RETIE with RETIE_EN=1, the earliest re-entry is the cycle after IDLE is reached, when INSTR_BND=1.

Test Plan:
- Reset mid-operation:
  - Drive C_SET=1 and Z_LD=1 with Z_IN=1, then RST_N=0 while in ISR.
  - Required: all outputs read 0 immediately and the FSM is IDLE.
- C priority:
  - C_CLEAR=1, C_SET=1, C_LD=1 with C_IN=1 in the same cycle -> C_FLAG=0.
  - C_SET=1, C_LD=1 with C_IN=0 -> C_FLAG=1.
- Masked interrupt:
  - I_FLAG=0, INTR pulse, INSTR_BND=1 -> no INT_TAKEN.
  - Then I_SET=1 and INSTR_BND=1 a few cycles later -> INT_TAKEN pulses exactly once.
- Entry and restore:
  - Start with C=1, Z=0, I=1; raise INTR; INSTR_BND=1.
  - Required at entry: INT_TAKEN high for exactly 1 cycle, at SYNC_STAGES+2 edges after INTR; IN_ISR=1; I_FLAG=0.
  - Inside the ISR, apply C_CLEAR and Z_LD with Z_IN=1 -> C=0, Z=1.
  - Then RETIE=1 with RETIE_EN=1 -> C=1, Z=0, I=1, IN_ISR=0.
- Restore override:
  - RETIE=1 together with C_SET=1 while shadow C=0 -> C_FLAG=0.
  - RETIE_EN=0 -> I_FLAG=0.
- Interrupt during ISR with ISR_GUARD=1:
  - INTR pulse while IN_ISR=1, then RETIE with RETIE_EN=1 and INSTR_BND=1 -> second INT_TAKEN one cycle after IDLE is reached.
  - With ISR_GUARD=0, the same stimulus produces no second INT_TAKEN.
